// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared state encoding and run counter constants for the program loader
package loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_FLUSH = 3'd2,
      S_RUN   = 3'd3,
      S_DONE  = 3'd4,
      S_ERROR = 3'd5
   } state_t;

   localparam int RUN_CNT_WIDTH = 16;
   localparam logic [RUN_CNT_WIDTH-1:0] SAT_MAX = 16'hFFFF;

endpackage

// File: rtl/run_watchdog.sv
// rtl/run_watchdog.sv - saturating run cycle counter with clear/enable and timeout compare
module run_watchdog
   import loader_pkg::*;
#(
   parameter int TIMEOUT = 1000
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     i_clear,
   input  logic                     i_enable,
   output logic [RUN_CNT_WIDTH-1:0] o_count,
   output logic                     o_timeout
);

   logic [RUN_CNT_WIDTH-1:0] r_count;
   logic [RUN_CNT_WIDTH:0]   w_next;

   // One extra bit so the compare never wraps when the counter sits at its maximum.
   assign w_next    = {1'b0, r_count} + (RUN_CNT_WIDTH+1)'(1);
   // Fires in the cycle whose closing edge would bring the count to TIMEOUT.
   assign o_timeout = i_enable && (w_next >= (RUN_CNT_WIDTH+1)'(TIMEOUT));
   assign o_count   = r_count;

   // Count enabled cycles, holding at the saturation value; clear wins over enable.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != SAT_MAX)) begin
         r_count <= w_next[RUN_CNT_WIDTH-1:0];
      end
   end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - streams a program into instruction memory, runs the processor, watches halt
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int MAX_WORDS  = 256,
   parameter int TIMEOUT    = 1000
) (
   input  logic                     clock,
   input  logic                     resetn,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic [15:0]              in_data,
   input  logic                     in_last,
   output logic                     in_ready,
   output logic                     mem_we,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   output logic [15:0]              mem_wdata,
   output logic                     cpu_resetn,
   input  logic                     cpu_halt,
   output logic                     busy,
   output logic                     done,
   output logic                     error,
   output logic [ADDR_WIDTH:0]      word_count,
   output logic [RUN_CNT_WIDTH-1:0] run_cycles
);

   localparam logic [ADDR_WIDTH:0] C_LAST_IDX = (ADDR_WIDTH+1)'(MAX_WORDS - 1);

   state_t                  r_state;
   logic                    r_in_ready;
   logic                    r_mem_we;
   logic [ADDR_WIDTH-1:0]   r_mem_addr;
   logic [15:0]             r_mem_wdata;
   logic                    r_cpu_resetn;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_error;
   logic [ADDR_WIDTH:0]     r_word_count;

   logic                    w_start_ok;
   logic                    w_run_en;
   logic                    w_timeout;
   logic                    w_handshake;

   // start is only honoured while the loader is parked; RUN ignores it.
   assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERROR));
   assign w_run_en    = (r_state == S_RUN);
   assign w_handshake = in_valid && r_in_ready;

   run_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_run_watchdog (
      .clock     (clock),
      .resetn    (resetn),
      .i_clear   (w_start_ok),
      .i_enable  (w_run_en),
      .o_count   (run_cycles),
      .o_timeout (w_timeout)
   );

   // Main sequencer: every output is a register updated alongside the state.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state      <= S_IDLE;
         r_in_ready   <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_cpu_resetn <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_word_count <= '0;
      end else begin
         r_mem_we <= 1'b0;
         case (r_state)
            S_IDLE, S_DONE, S_ERROR: begin
               if (w_start_ok) begin
                  r_state      <= S_LOAD;
                  r_in_ready   <= 1'b1;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_error      <= 1'b0;
                  r_cpu_resetn <= 1'b0;
                  r_word_count <= '0;
               end
            end
            S_LOAD: begin
               if (w_handshake) begin
                  r_mem_we     <= 1'b1;
                  r_mem_addr   <= r_word_count[ADDR_WIDTH-1:0];
                  r_mem_wdata  <= in_data;
                  r_word_count <= r_word_count + 1'b1;
                  if (in_last) begin
                     r_state    <= S_FLUSH;
                     r_in_ready <= 1'b0;
                  end else if (r_word_count == C_LAST_IDX) begin
                     // Capacity reached without a terminator: keep the word, flag overflow.
                     r_state    <= S_ERROR;
                     r_in_ready <= 1'b0;
                     r_busy     <= 1'b0;
                     r_error    <= 1'b1;
                  end
               end
            end
            S_FLUSH: begin
               r_state      <= S_RUN;
               r_cpu_resetn <= 1'b1;
            end
            S_RUN: begin
               if (cpu_halt) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else if (w_timeout) begin
                  r_state      <= S_ERROR;
                  r_busy       <= 1'b0;
                  r_error      <= 1'b1;
                  r_cpu_resetn <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;
   assign cpu_resetn = r_cpu_resetn;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;
   assign word_count = r_word_count;

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed scoreboard bench for program_loader
module tb_program_loader;

   localparam int AW = 8;
   localparam int MW = 4;
   localparam int TO = 20;

   logic          clock = 1'b0;
   logic          resetn = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [15:0]   in_data = 16'h0000;
   logic          in_last = 1'b0;
   logic          cpu_halt = 1'b0;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata;
   logic          cpu_resetn;
   logic          busy;
   logic          done;
   logic          error;
   logic [AW:0]   word_count;
   logic [15:0]   run_cycles;

   int            n_checks = 0;
   int            n_pass = 0;
   int            n_writes = 0;
   int            exp_wc = 0;
   int            w0;
   logic [23:0]   exp_q[$];

   program_loader #(
      .ADDR_WIDTH (AW),
      .MAX_WORDS  (MW),
      .TIMEOUT    (TO)
   ) dut (
      .clock      (clock),
      .resetn     (resetn),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_resetn (cpu_resetn),
      .cpu_halt   (cpu_halt),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .word_count (word_count),
      .run_cycles (run_cycles)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
      exp_wc = 0;
   endtask

   task automatic send(input logic [15:0] d, input logic last);
      logic [31:0] a;
      a = exp_wc;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      exp_q.push_back({a[7:0], d});
      exp_wc++;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 16'($urandom);
      check("word_count", word_count, exp_wc);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_in_ready"}, in_ready, 0);
      check({tag, "_mem_we"}, mem_we, 0);
      check({tag, "_cpu_resetn"}, cpu_resetn, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_error"}, error, 0);
      check({tag, "_word_count"}, word_count, 0);
      check({tag, "_run_cycles"}, run_cycles, 0);
   endtask

   // Write monitor: every strobe must match the oldest outstanding expected write.
   always @(negedge clock) begin : mon
      logic [23:0] e;
      if (resetn === 1'b1 && mem_we === 1'b1) begin
         n_writes++;
         check("write_expected", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("mem_addr", mem_addr, e[23:16]);
            check("mem_wdata", mem_wdata, e[15:0]);
         end
      end
   end

   initial begin
      // Reset state
      #1 resetn = 1'b0;
      #2 check_all_zero("reset");
      tick();
      tick();
      resetn = 1'b1;
      tick();
      check("idle_in_ready", in_ready, 0);

      // Load and run
      do_start();
      check("load_in_ready", in_ready, 1);
      check("load_busy", busy, 1);
      check("load_cpu_resetn", cpu_resetn, 0);
      send(16'h1005, 1'b0);
      send(16'h2003, 1'b0);
      send(16'hE000, 1'b1);
      check("flush_in_ready", in_ready, 0);
      check("flush_cpu_resetn", cpu_resetn, 0);
      tick();
      check("run_cpu_resetn", cpu_resetn, 1);
      check("run_busy", busy, 1);
      check("run_wc_hold", word_count, 3);

      // Normal halt after 10 RUN cycles
      repeat (9) tick();
      check("run_cycles_9", run_cycles, 9);
      check("no_done_yet", done, 0);
      cpu_halt = 1'b1;
      tick();
      cpu_halt = 1'b0;
      check("halt_done", done, 1);
      check("halt_run_cycles", run_cycles, 10);
      check("halt_cpu_resetn", cpu_resetn, 1);
      check("halt_busy", busy, 0);
      tick();
      tick();
      check("done_hold_cycles", run_cycles, 10);
      check("done_hold_cpu", cpu_resetn, 1);

      // Backpressure with gaps: valid 1,0,0,1
      w0 = n_writes;
      do_start();
      check("restart_done_clr", done, 0);
      check("restart_cpu_resetn", cpu_resetn, 0);
      check("restart_wc", word_count, 0);
      check("restart_cycles", run_cycles, 0);
      send(16'($urandom), 1'b0);
      in_last = 1'b1;
      tick();
      check("gap1_mem_we", mem_we, 0);
      tick();
      check("gap2_mem_we", mem_we, 0);
      check("gap_wc", word_count, 1);
      send(16'($urandom), 1'b1);
      tick();
      check("gap_write_count", n_writes - w0, 2);
      cpu_halt = 1'b1;
      tick();
      cpu_halt = 1'b0;
      check("quick_halt_done", done, 1);
      check("quick_halt_cycles", run_cycles, 1);

      // Overflow at MAX_WORDS without in_last
      do_start();
      for (int i = 0; i < MW; i++) send(16'($urandom), 1'b0);
      check("ovf_error", error, 1);
      check("ovf_cpu_resetn", cpu_resetn, 0);
      check("ovf_in_ready", in_ready, 0);
      check("ovf_busy", busy, 0);
      in_valid = 1'b1;
      tick();
      tick();
      in_valid = 1'b0;
      check("ovf_wc_hold", word_count, MW);
      do_start();
      check("ovf_clear_error", error, 0);
      check("ovf_reload_ready", in_ready, 1);
      check("ovf_reload_wc", word_count, 0);

      // Watchdog fires at run_cycles == TIMEOUT
      send(16'($urandom), 1'b1);
      tick();
      check("wd_run", cpu_resetn, 1);
      repeat (TO - 1) tick();
      check("wd_cycles_pre", run_cycles, TO - 1);
      check("wd_no_error_pre", error, 0);
      tick();
      check("wd_error", error, 1);
      check("wd_cycles", run_cycles, TO);
      check("wd_cpu_resetn", cpu_resetn, 0);
      check("wd_done", done, 0);

      // Halt in the timeout cycle wins
      do_start();
      send(16'($urandom), 1'b1);
      tick();
      repeat (TO - 1) tick();
      cpu_halt = 1'b1;
      tick();
      cpu_halt = 1'b0;
      check("wd_halt_done", done, 1);
      check("wd_halt_error", error, 0);
      check("wd_halt_cycles", run_cycles, TO);

      // Asynchronous reset mid-LOAD
      do_start();
      send(16'($urandom), 1'b0);
      send(16'($urandom), 1'b0);
      @(negedge clock);
      #1 resetn = 1'b0;
      #1 check_all_zero("async_rst");
      #5 resetn = 1'b1;
      tick();
      check("post_rst_idle", in_ready, 0);
      do_start();
      send(16'hBEEF, 1'b1);
      tick();
      check("post_rst_run", cpu_resetn, 1);
      check("sb_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
